timestamp_capture: RTL and testbench

Parametrised free-running timestamp counter with per-channel event capture. One counter advances by a fixed step per enabled clock. Each of N_CH event inputs latches the counter value on its rising edge into a holding register, which downstream logic drains with a valid/ready handshake. It sits between the photodetector/trigger edge logic and the readout path, and replaces the fixed 32-bit single-output timer.

---
 rtl/timestamp_pkg.sv | 28 ++
 rtl/ts_channel.sv | 67 ++++++
 rtl/timestamp_capture.sv | 99 +++++++++
 tb/tb_timestamp_capture.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timestamp_pkg.sv
// ============================================================================
// Module      : timestamp_pkg
// Description : Shared types and parameter defaults for timestamp_capture.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package timestamp_pkg;

  localparam int c_WIDTH_DEF = 32;
  localparam int c_STEP_DEF  = 10;
  localparam int c_N_CH_DEF  = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  // Default-width view of the control state; the top re-declares the same
  // shape with its own WIDTH because package types cannot be parametrised.
  typedef struct packed {
    state_e                 state;
    logic [c_WIDTH_DEF-1:0] counter;
  } core_s;

endpackage

`default_nettype wire

// File: rtl/ts_channel.sv
// ============================================================================
// Module      : ts_channel
// Description : One capture channel: edge detect, holding register,
//               valid/ready drain and sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ts_channel
  import timestamp_pkg::*;
#(
  parameter int WIDTH = c_WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             event_i,
  input  logic [WIDTH-1:0] counter_i,
  output logic [WIDTH-1:0] ts_o,
  output logic             ts_valid_o,
  input  logic             ts_ready_i,
  output logic             overflow_o
);

  logic             r_ev_s;
  logic             r_ev_q;
  logic             r_valid;
  logic             r_ovf;
  logic [WIDTH-1:0] r_ts;
  logic             w_edge;
  logic             w_accept;
  logic             w_drop;

  // The edge is taken one cycle after the event is sampled, so the captured
  // value is the counter seen in the edge cycle.
  assign w_edge   = r_ev_s & ~r_ev_q;
  assign w_accept = w_edge & (~r_valid | ts_ready_i);
  assign w_drop   = w_edge & r_valid & ~ts_ready_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_ev_s  <= 1'b0;
      r_ev_q  <= 1'b0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_ts    <= '0;
    end else begin
      r_ev_s <= event_i;
      r_ev_q <= r_ev_s;
      if (w_accept) begin
        r_ts    <= counter_i;
        r_valid <= 1'b1;
      end else if (r_valid && ts_ready_i) begin
        r_valid <= 1'b0;
      end
      // A drop in the clearing cycle still leaves the flag set.
      r_ovf <= (r_ovf & ~clear_i) | w_drop;
    end
  end

  assign ts_o       = r_ts;
  assign ts_valid_o = r_valid;
  assign overflow_o = r_ovf;

endmodule

`default_nettype wire

// File: rtl/timestamp_capture.sv
// ============================================================================
// Module      : timestamp_capture
// Description : Free-running stepped timestamp counter with per-channel
//               event capture and valid/ready readout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timestamp_capture
  import timestamp_pkg::*;
#(
  parameter int WIDTH = c_WIDTH_DEF,
  parameter int STEP  = c_STEP_DEF,
  parameter int N_CH  = c_N_CH_DEF
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic                  clear_i,
  input  logic [N_CH-1:0]       event_i,
  output logic [WIDTH-1:0]      time_o,
  output logic                  wrap_o,
  output logic [N_CH*WIDTH-1:0] ts_o,
  output logic [N_CH-1:0]       ts_valid_o,
  input  logic [N_CH-1:0]       ts_ready_i,
  output logic [N_CH-1:0]       overflow_o
);

  typedef struct packed {
    state_e           state;
    logic [WIDTH-1:0] counter;
  } core_t;

  localparam logic [WIDTH:0] c_STEP_EXT = (WIDTH+1)'(STEP);

  core_t          r_core;
  core_t          w_core_d;
  logic           r_wrap;
  logic           w_wrap_d;
  logic [WIDTH:0] w_sum;

  assign w_sum = {1'b0, r_core.counter} + c_STEP_EXT;

  always_comb begin
    w_core_d = r_core;
    w_wrap_d = 1'b0;
    case (r_core.state)
      IDLE: begin
        if (enable_i) w_core_d.state = COUNT;
      end
      COUNT: begin
        if (!enable_i) begin
          w_core_d.state = IDLE;
        end else begin
          w_core_d.counter = w_sum[WIDTH-1:0];
          w_wrap_d         = w_sum[WIDTH];
        end
      end
    endcase
    if (clear_i) begin
      w_core_d.counter = '0;
      w_wrap_d         = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_core <= '{state: IDLE, counter: '0};
      r_wrap <= 1'b0;
    end else begin
      r_core <= w_core_d;
      r_wrap <= w_wrap_d;
    end
  end

  assign time_o = r_core.counter;
  assign wrap_o = r_wrap;

  generate
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
      ts_channel #(
        .WIDTH(WIDTH)
      ) u_ch (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clear_i    (clear_i),
        .event_i    (event_i[k]),
        .counter_i  (r_core.counter),
        .ts_o       (ts_o[k*WIDTH +: WIDTH]),
        .ts_valid_o (ts_valid_o[k]),
        .ts_ready_i (ts_ready_i[k]),
        .overflow_o (overflow_o[k])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_timestamp_capture.sv
// ============================================================================
// Module      : tb_timestamp_capture
// Description : Self-checking bench for timestamp_capture (WIDTH=8, STEP=10).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timestamp_capture;

  localparam int W  = 8;
  localparam int ST = 10;
  localparam int NC = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            en = 1'b0;
  logic            clr = 1'b0;
  logic [NC-1:0]   ev = '0;
  logic [NC-1:0]   rdy = '0;
  logic [W-1:0]    time_o;
  logic            wrap;
  logic [NC*W-1:0] ts;
  logic [NC-1:0]   tsv;
  logic [NC-1:0]   ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  timestamp_capture #(.WIDTH(W), .STEP(ST), .N_CH(NC)) dut (
    .clk_i      (clk),
    .reset_i    (rst),
    .enable_i   (en),
    .clear_i    (clr),
    .event_i    (ev),
    .time_o     (time_o),
    .wrap_o     (wrap),
    .ts_o       (ts),
    .ts_valid_o (tsv),
    .ts_ready_i (rdy),
    .overflow_o (ovf)
  );

  // Reference model: counter and per-channel acceptance; accepted captures
  // are pushed to the scoreboard queues.
  logic [W-1:0]  m_cnt;
  logic          m_st;
  logic [NC-1:0] m_s, m_q, m_valid;
  logic [W:0]    m_sum;
  logic [W-1:0]  q0[$];
  logic [W-1:0]  q1[$];

  assign m_sum = {1'b0, m_cnt} + (W+1)'(ST);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt   <= '0;
      m_st    <= 1'b0;
      m_s     <= '0;
      m_q     <= '0;
      m_valid <= '0;
      q0.delete();
      q1.delete();
    end else begin
      for (int k = 0; k < NC; k++) begin
        if (m_s[k] && !m_q[k]) begin
          if (!m_valid[k] || rdy[k]) begin
            if (k == 0) q0.push_back(m_cnt);
            else        q1.push_back(m_cnt);
            m_valid[k] <= 1'b1;
          end
        end else if (m_valid[k] && rdy[k]) begin
          m_valid[k] <= 1'b0;
        end
      end
      m_q <= m_s;
      m_s <= ev;
      if (clr)             m_cnt <= '0;
      else if (m_st && en) m_cnt <= m_sum[W-1:0];
      m_st <= en;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; clr = 1'b0; ev = '0; rdy = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_time(input logic [W-1:0] v, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (m_cnt == v) ok = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: timeout waiting for time %0d, time_o=%0d", nm, v, time_o);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (time_o !== '0) begin errors++; $display("FAIL reset_time: got %0d expected 0", time_o); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %0b expected 0", wrap); end
    checks++; if (ts !== '0)     begin errors++; $display("FAIL reset_ts: got %0h expected 0", ts); end
    checks++; if (tsv !== '0)    begin errors++; $display("FAIL reset_valid: got %0b expected 0", tsv); end
    checks++; if (ovf !== '0)    begin errors++; $display("FAIL reset_ovf: got %0b expected 0", ovf); end
  endtask

  task automatic test_count();
    logic [W-1:0] exp_seq [5] = '{8'd0, 8'd0, 8'd10, 8'd20, 8'd30};
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (time_o !== exp_seq[i] || time_o !== m_cnt) begin
        errors++;
        $display("FAIL count_seq[%0d]: got %0d expected %0d", i, time_o, exp_seq[i]);
      end
      @(negedge clk);
    end
    // Leave a capture pending so the reset lands mid-handshake.
    ev[0] = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (time_o !== '0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_time: got time %0d wrap %0b expected 0 0", time_o, wrap);
    end
    checks++;
    if (ts !== '0 || tsv !== '0 || ovf !== '0) begin
      errors++;
      $display("FAIL async_reset_ch: got ts %0h valid %0b ovf %0b expected 0", ts, tsv, ovf);
    end
    @(negedge clk);
    rst = 1'b0; ev = '0; en = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    en = 1'b1;
    wait_time(8'd250, "wrap_wait");
    checks++; if (time_o !== 8'd250) begin errors++; $display("FAIL wrap_pre: got %0d expected 250", time_o); end
    @(negedge clk);
    checks++; if (time_o !== 8'd4) begin errors++; $display("FAIL wrap_value: got %0d expected 4", time_o); end
    checks++; if (wrap !== 1'b1)   begin errors++; $display("FAIL wrap_pulse: got %0b expected 1", wrap); end
    en = 1'b0;
    @(negedge clk);
    checks++; if (wrap !== 1'b0)   begin errors++; $display("FAIL wrap_one_cycle: got %0b expected 0", wrap); end
    repeat (3) @(negedge clk);
    checks++; if (time_o !== 8'd4) begin errors++; $display("FAIL hold: got %0d expected 4", time_o); end
  endtask

  task automatic test_capture();
    logic [W-1:0] exp_v;
    int lat = -1;
    do_reset();
    en = 1'b1; rdy = 2'b01;
    wait_time(8'd100, "cap_wait");
    ev[0] = 1'b1;
    for (int i = 1; i <= 6 && lat < 0; i++) begin
      @(negedge clk);
      if (i == 2) ev[0] = 1'b0;
      if (tsv[0]) lat = i;
    end
    checks++; if (lat != 2) begin errors++; $display("FAIL cap_latency: got %0d expected 2", lat); end
    exp_v = (q0.size() > 0) ? q0.pop_front() : 'x;
    checks++;
    if (ts[W-1:0] !== exp_v || ts[W-1:0] !== 8'd110) begin
      errors++;
      $display("FAIL cap_value: got %0d expected %0d", ts[W-1:0], exp_v);
    end
    @(negedge clk);
    checks++; if (tsv[0] !== 1'b0) begin errors++; $display("FAIL cap_pulse: got %0b expected 0", tsv[0]); end
    checks++; if (ts[W-1:0] !== 8'd110) begin errors++; $display("FAIL cap_keep: got %0d expected 110", ts[W-1:0]); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] exp_v;
    do_reset();
    en = 1'b1; rdy = 2'b00;
    wait_time(8'd50, "ovf_wait1");
    ev[1] = 1'b1; repeat (2) @(negedge clk); ev[1] = 1'b0;
    wait_time(8'd200, "ovf_wait2");
    ev[1] = 1'b1; repeat (2) @(negedge clk); ev[1] = 1'b0;
    repeat (2) @(negedge clk);
    exp_v = (q1.size() > 0) ? q1.pop_front() : 'x;
    checks++;
    if (ts[2*W-1:W] !== exp_v || ts[2*W-1:W] !== 8'd60) begin
      errors++;
      $display("FAIL ovf_kept: got %0d expected %0d", ts[2*W-1:W], exp_v);
    end
    checks++; if (q1.size() != 0) begin errors++; $display("FAIL ovf_dropped: got %0d extra captures expected 0", q1.size()); end
    checks++; if (tsv[1] !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %0b expected 1", tsv[1]); end
    checks++; if (ovf !== 2'b10)   begin errors++; $display("FAIL ovf_flag: got %0b expected 10", ovf); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++; if (ovf[1] !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %0b expected 0", ovf[1]); end
    checks++; if (tsv[1] !== 1'b1) begin errors++; $display("FAIL clr_valid: got %0b expected 1", tsv[1]); end
    checks++; if (time_o !== '0)   begin errors++; $display("FAIL clr_time: got %0d expected 0", time_o); end
    rdy[1] = 1'b1;
    @(negedge clk);
    checks++; if (tsv[1] !== 1'b0) begin errors++; $display("FAIL drain: got %0b expected 0", tsv[1]); end
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] e0, e1;
    bit seen = 1'b0;
    do_reset();
    en = 1'b1; rdy = 2'b11;
    wait_time(8'd30, "sim_wait");
    ev = 2'b11;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (tsv != 2'b00) seen = 1'b1;
    end
    ev = 2'b00;
    e0 = (q0.size() > 0) ? q0.pop_front() : 'x;
    e1 = (q1.size() > 0) ? q1.pop_front() : 'x;
    checks++; if (tsv !== 2'b11) begin errors++; $display("FAIL sim_valid: got %0b expected 11", tsv); end
    checks++;
    if (ts[W-1:0] !== e0 || ts[2*W-1:W] !== e1 || e0 !== 8'd40) begin
      errors++;
      $display("FAIL sim_values: got %0d/%0d expected %0d/%0d", ts[W-1:0], ts[2*W-1:W], e0, e1);
    end
  endtask

  task automatic test_clear_edge();
    logic [W-1:0] exp_v;
    do_reset();
    en = 1'b1; rdy = 2'b01;
    wait_time(8'd70, "clr_edge_wait");
    ev[0] = 1'b1;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; ev[0] = 1'b0;
    exp_v = (q0.size() > 0) ? q0.pop_front() : 'x;
    checks++; if (time_o !== '0) begin errors++; $display("FAIL clr_edge_time: got %0d expected 0", time_o); end
    checks++; if (tsv[0] !== 1'b1) begin errors++; $display("FAIL clr_edge_valid: got %0b expected 1", tsv[0]); end
    checks++;
    if (ts[W-1:0] !== exp_v || ts[W-1:0] !== 8'd80) begin
      errors++;
      $display("FAIL clr_edge_value: got %0d expected %0d", ts[W-1:0], exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_capture();
    test_overflow();
    test_simultaneous();
    test_clear_edge();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

endmodule

`default_nettype wire
